fmmu_multi_ch: RTL and testbench

Parametrised multi-channel FMMU mapper: accepts one logical datagram window (`sub_address`, `sub_len`) and scans `N_CH` configured FMMU channels in sequence. For every channel whose logical window overlaps the request, it emits one mapping segment: physical bus address, segment length and byte offset within the datagram. Segments are delivered over a valid/ready handshake. The block sits between the datagram parser and the local-memory bus arbiter and replaces the single-channel combinational mapper.

---
 rtl/fmmu_pkg.sv | 20 ++
 rtl/fmmu_multi_ch_if.sv | 35 +++
 rtl/fmmu_overlap.sv | 32 +++
 rtl/fmmu_multi_ch.sv | 118 +++++++++++
 tb/tb_fmmu_multi_ch.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fmmu_pkg.sv
// fmmu_pkg: shared state encoding, default widths and flattened-bus slice helpers for fmmu_multi_ch
package fmmu_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    localparam int N_CH_D    = 4;
    localparam int ADDR_W_D  = 32;
    localparam int PADDR_W_D = 16;
    localparam int LEN_W_D   = 8;
    localparam int MAX_CH    = 16;
    localparam int MAX_W     = 64;
    localparam int BUS_W     = MAX_CH * MAX_W;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Extracts field idx of width w from a zero-padded flattened configuration bus.
    function automatic logic [MAX_W-1:0] cfg_slice(input logic [BUS_W-1:0] flat, input int idx, input int w);
        logic [BUS_W-1:0] sh;
        sh = flat >> (idx * w);
        return sh[MAX_W-1:0] & ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction
endpackage

// File: rtl/fmmu_multi_ch_if.sv
// fmmu_multi_ch_if: request and mapping-segment handshake bundle
// master: drives sub_address/sub_len/sub_dir/subdv and map_ready (datagram parser / consumer side)
// slave : drives sub_ready, map_valid, bus_address, fmmu_map_address_len, map_offset, map_channel, done, hit_count
interface fmmu_multi_ch_if
    import fmmu_pkg::*;
#(
    parameter int N_CH    = N_CH_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int PADDR_W = PADDR_W_D,
    parameter int LEN_W   = LEN_W_D
);
    localparam int CH_W = ch_w(N_CH);
    localparam int HC_W = $clog2(N_CH + 1);
    logic [ADDR_W-1:0]  sub_address;
    logic [LEN_W-1:0]   sub_len;
    logic               sub_dir;
    logic               subdv;
    logic               sub_ready;
    logic               map_valid;
    logic               map_ready;
    logic [PADDR_W-1:0] bus_address;
    logic [LEN_W-1:0]   fmmu_map_address_len;
    logic [LEN_W-1:0]   map_offset;
    logic [CH_W-1:0]    map_channel;
    logic               done;
    logic [HC_W-1:0]    hit_count;
    modport master (
        output sub_address, sub_len, sub_dir, subdv, map_ready,
        input  sub_ready, map_valid, bus_address, fmmu_map_address_len, map_offset, map_channel, done, hit_count
    );
    modport slave (
        input  sub_address, sub_len, sub_dir, subdv, map_ready,
        output sub_ready, map_valid, bus_address, fmmu_map_address_len, map_offset, map_channel, done, hit_count
    );
endinterface

// File: rtl/fmmu_overlap.sv
// fmmu_overlap: combinational overlap of a request window with one FMMU channel window
// i_a/i_n: request start/length; i_l/i_len: channel start/length; i_p: channel physical start
// o_hit: windows intersect; o_bus/o_len/o_off: physical address, length, offset of the intersection
module fmmu_overlap #(
    parameter int ADDR_W  = 32,
    parameter int PADDR_W = 16,
    parameter int LEN_W   = 8
) (
    input  logic [ADDR_W-1:0]  i_a,
    input  logic [LEN_W-1:0]   i_n,
    input  logic [ADDR_W-1:0]  i_l,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [PADDR_W-1:0] i_p,
    output logic               o_hit,
    output logic [PADDR_W-1:0] o_bus,
    output logic [LEN_W-1:0]   o_len,
    output logic [LEN_W-1:0]   o_off
);
    localparam int AW1 = ADDR_W + 1;
    // One extra bit keeps window ends past 2^ADDR_W from wrapping to low addresses.
    logic [ADDR_W:0] w_a, w_l, w_a_end, w_l_end, w_lo, w_hi;
    assign w_a     = {1'b0, i_a};
    assign w_l     = {1'b0, i_l};
    assign w_a_end = w_a + AW1'(i_n);
    assign w_l_end = w_l + AW1'(i_len);
    assign w_lo    = (w_a > w_l) ? w_a : w_l;
    assign w_hi    = (w_a_end < w_l_end) ? w_a_end : w_l_end;
    assign o_hit   = (i_n != '0) && (i_len != '0) && (w_lo < w_hi);
    assign o_bus   = i_p + PADDR_W'(w_lo - w_l);
    assign o_len   = LEN_W'(w_hi - w_lo);
    assign o_off   = LEN_W'(w_lo - w_a);
endmodule

// File: rtl/fmmu_multi_ch.sv
// fmmu_multi_ch: scans N_CH FMMU channels for one logical request and emits one mapping segment per hit
// clk/RST: rising-edge clock, synchronous active-high reset
// io (slave): request handshake in, mapping segments out, done pulse with hit_count
// cfg_*/fmmu_*: per-channel enables, direction permits and flattened logical/physical windows
// Macro FMMU_DIR_CHECK_EN: when defined a hit also needs cfg_rd_en/cfg_wr_en for the request direction
module fmmu_multi_ch
    import fmmu_pkg::*;
#(
    parameter int N_CH    = N_CH_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int PADDR_W = PADDR_W_D,
    parameter int LEN_W   = LEN_W_D
) (
    input  logic                    clk,
    input  logic                    RST,
    fmmu_multi_ch_if.slave          io,
    input  logic [N_CH-1:0]         cfg_enable,
    input  logic [N_CH-1:0]         cfg_rd_en,
    input  logic [N_CH-1:0]         cfg_wr_en,
    input  logic [N_CH*ADDR_W-1:0]  fmmu_logic_address_start,
    input  logic [N_CH*LEN_W-1:0]   fmmu_logic_length,
    input  logic [N_CH*PADDR_W-1:0] fmmu_physical_address_start
);
    localparam int CH_W = ch_w(N_CH);
    localparam int HC_W = $clog2(N_CH + 1);
    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_dir;
    logic [CH_W-1:0]    r_ch, r_mch;
    logic [HC_W-1:0]    r_hits;
    logic [PADDR_W-1:0] r_bus;
    logic [LEN_W-1:0]   r_mlen, r_off;
    logic [ADDR_W-1:0]  w_l;
    logic [LEN_W-1:0]   w_len;
    logic [PADDR_W-1:0] w_p;
    logic               w_ov_hit, w_dir_ok, w_hit, w_last;
    logic [PADDR_W-1:0] w_bus;
    logic [LEN_W-1:0]   w_mlen, w_off;
    assign w_l    = ADDR_W'(cfg_slice(BUS_W'(fmmu_logic_address_start), int'(r_ch), ADDR_W));
    assign w_len  = LEN_W'(cfg_slice(BUS_W'(fmmu_logic_length), int'(r_ch), LEN_W));
    assign w_p    = PADDR_W'(cfg_slice(BUS_W'(fmmu_physical_address_start), int'(r_ch), PADDR_W));
    assign w_last = (r_ch == CH_W'(N_CH - 1));
    fmmu_overlap #(.ADDR_W(ADDR_W), .PADDR_W(PADDR_W), .LEN_W(LEN_W)) u_overlap (
        .i_a   (r_addr),
        .i_n   (r_len),
        .i_l   (w_l),
        .i_len (w_len),
        .i_p   (w_p),
        .o_hit (w_ov_hit),
        .o_bus (w_bus),
        .o_len (w_mlen),
        .o_off (w_off)
    );
`ifdef FMMU_DIR_CHECK_EN
    assign w_dir_ok = r_dir ? cfg_wr_en[r_ch] : cfg_rd_en[r_ch];
`else
    logic w_unused;
    assign w_unused = ^{cfg_rd_en, cfg_wr_en, r_dir};
    assign w_dir_ok = 1'b1;
`endif
    assign w_hit = w_ov_hit && cfg_enable[r_ch] && w_dir_ok;
    always_ff @(posedge clk) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = io.subdv ? SCAN : IDLE;
            SCAN:    w_next = w_hit ? EMIT : (w_last ? DONE : SCAN);
            EMIT:    w_next = io.map_ready ? (w_last ? DONE : SCAN) : EMIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            r_addr <= '0;
            r_len  <= '0;
            r_dir  <= 1'b0;
            r_ch   <= '0;
            r_hits <= '0;
            r_bus  <= '0;
            r_mlen <= '0;
            r_off  <= '0;
            r_mch  <= '0;
        end else begin
            if (r_state == IDLE && io.subdv) begin
                r_addr <= io.sub_address;
                r_len  <= io.sub_len;
                r_dir  <= io.sub_dir;
                r_ch   <= '0;
                r_hits <= '0;
            end
            if (r_state == SCAN) begin
                if (w_hit) begin
                    r_bus  <= w_bus;
                    r_mlen <= w_mlen;
                    r_off  <= w_off;
                    r_mch  <= r_ch;
                    r_hits <= r_hits + 1'b1;
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
            if (r_state == EMIT && io.map_ready) r_ch <= r_ch + 1'b1;
        end
    end
    assign io.sub_ready            = (r_state == IDLE);
    assign io.map_valid            = (r_state == EMIT);
    assign io.done                 = (r_state == DONE);
    assign io.bus_address          = r_bus;
    assign io.fmmu_map_address_len = r_mlen;
    assign io.map_offset           = r_off;
    assign io.map_channel          = r_mch;
    assign io.hit_count            = r_hits;
endmodule

// File: tb/tb_fmmu_multi_ch.sv
// tb_fmmu_multi_ch: directed self-checking bench for fmmu_multi_ch
module tb_fmmu_multi_ch;
    import fmmu_pkg::*;
    localparam int N = 4;
    logic clk = 1'b0;
    logic RST = 1'b1;
    logic [N-1:0]    cfg_enable, cfg_rd_en, cfg_wr_en;
    logic [N*32-1:0] la;
    logic [N*8-1:0]  ll;
    logic [N*16-1:0] pa;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    fmmu_multi_ch_if #(.N_CH(N), .ADDR_W(32), .PADDR_W(16), .LEN_W(8)) mif ();
    fmmu_multi_ch #(.N_CH(N), .ADDR_W(32), .PADDR_W(16), .LEN_W(8)) dut (
        .clk                         (clk),
        .RST                         (RST),
        .io                          (mif),
        .cfg_enable                  (cfg_enable),
        .cfg_rd_en                   (cfg_rd_en),
        .cfg_wr_en                   (cfg_wr_en),
        .fmmu_logic_address_start    (la),
        .fmmu_logic_length           (ll),
        .fmmu_physical_address_start (pa)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_ch(input int i, input logic [31:0] l, input logic [7:0] n, input logic [15:0] p);
        la[i*32 +: 32] = l;
        ll[i*8 +: 8]   = n;
        pa[i*16 +: 16] = p;
        cfg_enable[i]  = 1'b1;
    endtask
    task automatic send(input string tag, input logic [31:0] a, input logic [7:0] n, input logic d);
        int k = 0;
        while (!mif.sub_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, mif.sub_ready, 1);
        mif.sub_address = a;
        mif.sub_len     = n;
        mif.sub_dir     = d;
        mif.subdv       = 1'b1;
        @(negedge clk);
        mif.subdv = 1'b0;
        t0 = cyc;
        chk({tag, "_busy"}, mif.sub_ready, 0);
    endtask
    task automatic seg(input string tag, input logic [15:0] ba, input logic [7:0] ln, input logic [7:0] off,
                       input logic [1:0] ch, input int stall, input int lat);
        int k = 0;
        while (!mif.map_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, mif.map_valid, 1);
        if (lat >= 0) chk({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_hold_valid"}, mif.map_valid, 1);
            chk({tag, "_hold_bus"}, mif.bus_address, ba);
            chk({tag, "_hold_len"}, mif.fmmu_map_address_len, ln);
            @(negedge clk);
        end
        chk({tag, "_bus"}, mif.bus_address, ba);
        chk({tag, "_len"}, mif.fmmu_map_address_len, ln);
        chk({tag, "_off"}, mif.map_offset, off);
        chk({tag, "_ch"}, mif.map_channel, ch);
        mif.map_ready = 1'b1;
        @(negedge clk);
        mif.map_ready = 1'b0;
    endtask
    task automatic fin(input string tag, input int hits, input int lat);
        int k = 0;
        while (!mif.done && k < 50) begin
            chk({tag, "_novalid"}, mif.map_valid, 0);
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, mif.done, 1);
        if (lat >= 0) chk({tag, "_done_lat"}, 64'(cyc - t0), 64'(lat));
        chk({tag, "_hits"}, mif.hit_count, 64'(hits));
        @(negedge clk);
        chk({tag, "_done_pulse"}, mif.done, 0);
        chk({tag, "_ready_after"}, mif.sub_ready, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        mif.sub_address = '0;
        mif.sub_len     = '0;
        mif.sub_dir     = 1'b0;
        mif.subdv       = 1'b0;
        mif.map_ready   = 1'b0;
        cfg_enable = '0;
        cfg_rd_en  = '1;
        cfg_wr_en  = '1;
        la = '0;
        ll = '0;
        pa = '0;
        set_ch(0, 32'h14141414, 8'd3, 16'h1001);
        repeat (3) @(negedge clk);
        chk("rst_ready", mif.sub_ready, 1);
        chk("rst_valid", mif.map_valid, 0);
        chk("rst_done", mif.done, 0);
        chk("rst_hits", mif.hit_count, 0);
        chk("rst_bus", mif.bus_address, 0);
        chk("rst_len", mif.fmmu_map_address_len, 0);
        chk("rst_off", mif.map_offset, 0);
        chk("rst_ch", mif.map_channel, 0);
        RST = 1'b0;
        @(negedge clk);
        send("s1", 32'h14141413, 8'd2, 1'b0);
        seg("s1", 16'h1001, 8'd1, 8'd1, 2'd0, 0, 1);
        fin("s1", 1, N + 1);
        send("s2", 32'h14141415, 8'd4, 1'b0);
        seg("s2", 16'h1002, 8'd2, 8'd0, 2'd0, 0, 1);
        fin("s2", 1, N + 1);
        send("s3", 32'h14141412, 8'd8, 1'b0);
        seg("s3", 16'h1001, 8'd3, 8'd2, 2'd0, 5, 1);
        fin("s3", 1, -1);
        send("s4", 32'h10000000, 8'd1, 1'b0);
        fin("s4", 0, N);
        set_ch(2, 32'h14141416, 8'd4, 16'h2000);
        send("s5", 32'h14141414, 8'd8, 1'b0);
        seg("s5a", 16'h1001, 8'd3, 8'd0, 2'd0, 0, 1);
        seg("s5b", 16'h2000, 8'd4, 8'd2, 2'd2, 0, 4);
        fin("s5", 2, N + 2);
        send("s5z", 32'h14141414, 8'd0, 1'b0);
        fin("s5z", 0, N);
        cfg_enable[2] = 1'b0;
        set_ch(3, 32'hFFFFFFFE, 8'd4, 16'h3000);
        send("wrap_lo", 32'h00000000, 8'd2, 1'b0);
        fin("wrap_lo", 0, N);
        send("wrap_hi", 32'hFFFFFFFF, 8'd2, 1'b0);
        seg("wrap_hi", 16'h3001, 8'd2, 8'd0, 2'd3, 0, 4);
        fin("wrap_hi", 1, N + 1);
        cfg_enable[3] = 1'b0;
        cfg_wr_en[0] = 1'b0;
        send("dir", 32'h14141414, 8'd1, 1'b1);
`ifdef FMMU_DIR_CHECK_EN
        fin("dir", 0, N);
`else
        seg("dir", 16'h1001, 8'd1, 8'd0, 2'd0, 0, 1);
        fin("dir", 1, N + 1);
`endif
        send("rst_emit", 32'h14141414, 8'd1, 1'b0);
        seg("rst_emit_pre", 16'h1001, 8'd1, 8'd0, 2'd0, 1, 1);
        send("rst_emit2", 32'h14141414, 8'd2, 1'b0);
        begin
            int k = 0;
            while (!mif.map_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_emit_valid", mif.map_valid, 1);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        chk("rst_emit_valid_low", mif.map_valid, 0);
        chk("rst_emit_ready", mif.sub_ready, 1);
        chk("rst_emit_hits", mif.hit_count, 0);
        for (int i = 0; i < 6; i++) begin
            chk("rst_emit_nodone", mif.done, 0);
            @(negedge clk);
        end
        send("recover", 32'h14141413, 8'd2, 1'b0);
        seg("recover", 16'h1001, 8'd1, 8'd1, 2'd0, 0, 1);
        fin("recover", 1, N + 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
